cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single burst memory port between iCache and dCache refill/writeback traffic. Grants one requester at a time, forwards its address handshake and exactly `BURST_LEN` data beats, then releases the port. Uses round-robin between the two requesters. Sits between the two cache controllers and the cache-to-bus bridge.

## Interface
Parameters:
- `BURST_LEN`, default `2 ** (ICACHE_B - 2)` (8): data beats per transaction, power of two, ≥2.
- `CNT_W`, default `$clog2(BURST_LEN)`: beat counter width.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: iCache wants a read burst.
- `i_addr` in 32: iCache line address.
- `i_addr_ok` out 1: iCache address accepted.
- `i_data_ok` out 1: iCache beat valid.
- `i_rdata` out 32: read data.
- `d_req` in 1: dCache wants a burst.
- `d_wr` in 1: 1 = writeback, 0 = refill.
- `d_addr` in 32: dCache line address.
- `d_wdata` in 32: current writeback beat.
- `d_addr_ok` out 1: dCache address accepted.
- `d_data_ok` out 1: dCache beat done.
- `d_rdata` out 32: read data.
- `mem_req` out 1: memory request.
- `mem_wr` out 1: write request.
- `mem_addr` out 32: burst address.
- `mem_wdata` out 32: write beat.
- `mem_addr_ok` in 1: memory address accept.
- `mem_data_ok` in 1: memory beat done.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: state ≠ IDLE.
- `owner_d` out 1: current/last grant is dCache.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any request is present, pick a winner, latch its address and write flag into `own_addr` and `own_wr`, set `owner_d`, and go to ADDR.
  - If there is no request, stay in IDLE.
- Arbitration:
  - A single request wins.
  - If both request, the winner is the one not granted last (`last_d` register).
  - `last_d` resets to 0, so the first conflict after reset goes to dCache.
  - iCache grants always latch `own_wr = 0`.
- ADDR:
  - `mem_req = 1`, `mem_addr = own_addr`, `mem_wr = own_wr`.
  - On `mem_addr_ok`, pulse the owner's `*_addr_ok` in the same cycle, clear `cnt`, and go to DATA.
- DATA:
  - `mem_req = 0`.
  - Each `mem_data_ok` is forwarded combinationally as the owner's `*_data_ok`, and `cnt` increments.
  - When `mem_data_ok` arrives with `cnt == BURST_LEN-1`, go to IDLE and set `last_d = owner_d`.
- Data paths:
  - `i_rdata = d_rdata = mem_rdata` unconditionally; the owner qualifies it with `data_ok`.
  - `mem_wdata = d_wdata` whenever `own_wr`, else 0.
- Counter: `cnt` is CNT_W bits; the last beat is detected by compare, not by wrap-around.
- Boundary conditions:
  - `mem_data_ok` in IDLE or ADDR is ignored, not forwarded, and `cnt` is unchanged.
  - `mem_addr_ok` outside ADDR is ignored.
  - If the owner drops `req` mid-transaction, the burst still completes all `BURST_LEN` beats.
  - A non-owner's `req` has no effect until the next IDLE cycle.
  - If `mem_addr_ok` and `mem_data_ok` arrive in the same ADDR cycle, the data beat is ignored (protocol violation, flagged by an assertion).
  - The non-owner's `*_addr_ok` and `*_data_ok` are always 0.

## Timing
- Reset values:
  - State IDLE, `cnt = 0`, `last_d = 0`, `owner_d = 0`, `own_addr = 0`, `own_wr = 0`.
  - Hence `mem_req = 0`, `mem_wr = 0`, `mem_addr = 0`, `busy = 0`, and all `*_ok = 0`.
- Reset mid-burst: the next cycle is IDLE with `mem_req = 0`. Beats still in flight from memory are dropped.
- Request latency: `req` high in IDLE at cycle t gives `mem_req` at t+1.
- Address handshake: `mem_addr_ok` is combinationally forwarded to the owner's `*_addr_ok` in the same cycle.
- Back-to-back transactions:
  - The final beat at cycle t returns the block to IDLE at t+1.
  - The next grant's `mem_req` is at t+2, so there is a minimum one idle cycle between bursts.
- Minimum transaction length: 1 arbitration cycle + ≥1 ADDR cycle + `BURST_LEN` beat cycles.

## Structure
- Shared package `cache_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_ADDR, ARB_DATA}.
  - `BURST_LEN` derived from `ICACHE_B`.
- Single module; the round-robin pick is inline.
- Optional sub-module `beat_counter` (count, clear, last-beat flag), reusable by the dCache writeback path.

## Test plan
- Only `i_req`, addr 0x1FC0_0040, memory returns 8 beats 0..7 → `mem_req` one cycle after `req`, `mem_addr` 0x1FC0_0040, `mem_wr` 0, exactly 8 `i_data_ok` pulses, `d_*_ok` stay 0, `busy` falls after beat 7.
- `i_req` and `d_req` (`d_wr=1`, addr 0x8000_1000) raised in the same cycle after reset → dCache is granted first with `mem_wr=1` and `mem_wdata` following `d_wdata`. iCache is granted next, one idle cycle after dCache's beat 7.
- Both requests held continuously for 4 bursts → grants alternate D, I, D, I.
- Stray `mem_data_ok` during IDLE and ADDR → no `*_data_ok` pulse, `cnt` stays 0. The burst still takes exactly 8 beats after `addr_ok`.
- Owner drops `req` after beat 2 → beats 3..7 are still forwarded, then the block returns to IDLE.
- `reset` asserted in DATA with `cnt=5` → next cycle IDLE, `cnt=0`, `mem_req=0`. A following `i_req` is served normally with 8 beats.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: line geometry, burst length and the
// memory-port arbiter state encoding.
package cache_pkg;

  localparam int ICACHE_B  = 5;
  localparam int BURST_LEN = 2 ** (ICACHE_B - 2);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Round-robin pick between two requesters: on a conflict the side that
  // was not granted last wins. Returns 1 when dCache should be granted.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic last_d);
    return d_req && (!i_req || !last_d);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// Burst beat counter: cleared at the start of a burst, advanced once per
// beat, with a last-beat flag found by comparison rather than by wrap-around.
module beat_counter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(BURST_LEN - 1));

  // Returning to zero on the last beat keeps the counter idle-clean between bursts.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single burst memory port between iCache refills and dCache
// refill/writeback traffic, one full burst at a time, round-robin on conflict.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int BURST_LEN = cache_pkg::BURST_LEN,
  parameter int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        busy,
  output logic        owner_d
);

  arb_state_e       state_q, state_d;
  logic             last_d;
  logic [31:0]      own_addr;
  logic             own_wr;

  logic             grant_take;
  logic             grant_d;
  logic             addr_hs;
  logic             beat;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             burst_done;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat_last;

  beat_counter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (beat_cnt),
    .last  (beat_last)
  );

  // Next-state and handshake decode; beats and address accepts outside
  // their own state fall through to the defaults and are dropped.
  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    grant_d    = 1'b0;
    addr_hs    = 1'b0;
    beat       = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    burst_done = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant_take = 1'b1;
          grant_d    = pick_d(i_req, d_req, last_d);
          state_d    = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (mem_addr_ok) begin
          addr_hs   = 1'b1;
          cnt_clear = 1'b1;
          state_d   = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (mem_data_ok) begin
          beat    = 1'b1;
          cnt_inc = 1'b1;
          if (beat_last) begin
            burst_done = 1'b1;
            state_d    = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      last_d   <= 1'b0;
      owner_d  <= 1'b0;
      own_addr <= '0;
      own_wr   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        owner_d  <= grant_d;
        own_addr <= grant_d ? d_addr : i_addr;
        own_wr   <= grant_d && d_wr;
      end
      if (burst_done) begin
        last_d <= owner_d;
      end
    end
  end

  assign mem_req   = (state_q == ARB_ADDR);
  assign mem_addr  = own_addr;
  assign mem_wr    = own_wr;
  assign mem_wdata = own_wr ? d_wdata : 32'd0;

  assign i_addr_ok = addr_hs && !owner_d;
  assign d_addr_ok = addr_hs &&  owner_d;
  assign i_data_ok = beat && !owner_d;
  assign d_data_ok = beat &&  owner_d;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign busy    = (state_q != ARB_IDLE);

  // Memory must not complete a beat in the same cycle it accepts the address.
  a_no_beat_with_addr_ok: assert property (@(posedge clk) disable iff (reset)
    !(state_q == ARB_ADDR && mem_addr_ok && mem_data_ok));

  a_cnt_zero_outside_data: assert property (@(posedge clk) disable iff (reset)
    (state_q != ARB_DATA) |-> (beat_cnt == '0));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single and conflicting requests,
// round-robin alternation, stray memory strobes, owner drop and mid-burst reset.
module tb_cache_mem_arbiter;

  localparam int BL = 8;
  localparam logic [31:0] I_ADDR  = 32'h1FC0_0040;
  localparam logic [31:0] D_ADDR  = 32'h8000_1000;
  localparam logic [31:0] I_ADDR2 = 32'h1FC0_0080;
  localparam logic [31:0] D_ADDR2 = 32'h8000_2000;

  logic        clk;
  logic        reset;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy, owner_d;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.BURST_LEN(BL)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_addr_ok   (i_addr_ok),
    .i_data_ok   (i_data_ok),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_addr_ok   (d_addr_ok),
    .d_data_ok   (d_data_ok),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .owner_d     (owner_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da);
    i_req  = ir;
    i_addr = ia;
    d_req  = dr;
    d_wr   = dw;
    d_addr = da;
  endtask

  // Entered at a negedge where the arbiter is in ADDR; leaves at the negedge
  // after the final beat, where it must be back in IDLE.
  task automatic serveBurst(input logic exp_d, input logic [31:0] exp_addr,
                            input logic exp_wr, input int addr_wait,
                            input int drop_after, input string tag);
    logic [31:0] exp_wdata;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    #1;
    checkOutput({tag, "_mem_req"},  32'(mem_req), 32'd1);
    checkOutput({tag, "_mem_addr"}, mem_addr, exp_addr);
    checkOutput({tag, "_mem_wr"},   32'(mem_wr), 32'(exp_wr));
    checkOutput({tag, "_owner_d"},  32'(owner_d), 32'(exp_d));
    checkOutput({tag, "_busy"},     32'(busy), 32'd1);
    for (int w = 0; w < addr_wait; w++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("%s_wait%0d_mem_req", tag, w), 32'(mem_req), 32'd1);
    end
    mem_addr_ok = 1'b1;
    #1;
    checkOutput({tag, "_addr_ok_own"}, 32'(exp_d ? d_addr_ok : i_addr_ok), 32'd1);
    checkOutput({tag, "_addr_ok_oth"}, 32'(exp_d ? i_addr_ok : d_addr_ok), 32'd0);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    for (int k = 0; k < BL; k++) begin
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hA500_0000 + k;
      d_wdata     = 32'h5A00_0000 + k;
      exp_wdata   = exp_wr ? (32'h5A00_0000 + k) : 32'd0;
      #1;
      checkOutput($sformatf("%s_beat%0d_ok_own", tag, k),
                  32'(exp_d ? d_data_ok : i_data_ok), 32'd1);
      checkOutput($sformatf("%s_beat%0d_ok_oth", tag, k),
                  32'(exp_d ? i_data_ok : d_data_ok), 32'd0);
      checkOutput($sformatf("%s_beat%0d_rdata", tag, k),
                  exp_d ? d_rdata : i_rdata, 32'hA500_0000 + k);
      checkOutput($sformatf("%s_beat%0d_wdata", tag, k), mem_wdata, exp_wdata);
      checkOutput($sformatf("%s_beat%0d_mem_req", tag, k), 32'(mem_req), 32'd0);
      if (k == drop_after) begin
        if (exp_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
      @(negedge clk);
    end
    mem_data_ok = 1'b0;
    #1;
    checkOutput({tag, "_end_busy"},    32'(busy), 32'd0);
    checkOutput({tag, "_end_mem_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_end_data_ok"}, 32'({i_data_ok, d_data_ok}), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    d_wdata     = 32'd0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    doReset();

    // Reset state, with stray memory strobes that must be ignored in IDLE.
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    d_wdata     = 32'hDEAD_BEEF;
    #1;
    checkOutput("rst_mem_req",   32'(mem_req), 32'd0);
    checkOutput("rst_mem_wr",    32'(mem_wr), 32'd0);
    checkOutput("rst_mem_addr",  mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_busy",      32'(busy), 32'd0);
    checkOutput("rst_owner_d",   32'(owner_d), 32'd0);
    checkOutput("rst_oks",       32'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 32'd0);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;

    // iCache alone, with a slow address accept.
    @(negedge clk);
    applyStimulus(1'b1, I_ADDR, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t1_req_latency", 32'(mem_req), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, I_ADDR, 1'b0, 1'b0, 32'd0);
    serveBurst(1'b0, I_ADDR, 1'b0, 2, -1, "t1");

    // Simultaneous requests after reset: dCache writeback first, then iCache.
    doReset();
    applyStimulus(1'b1, I_ADDR, 1'b1, 1'b1, D_ADDR);
    #1;
    checkOutput("t2_idle_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, I_ADDR, 1'b0, 1'b1, D_ADDR);
    serveBurst(1'b1, D_ADDR, 1'b1, 0, -1, "t2_d");
    @(negedge clk);
    applyStimulus(1'b0, I_ADDR, 1'b0, 1'b1, D_ADDR);
    serveBurst(1'b0, I_ADDR, 1'b0, 0, -1, "t2_i");

    // Both held continuously: grants alternate D, I, D, I.
    applyStimulus(1'b1, I_ADDR2, 1'b1, 1'b0, D_ADDR2);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      serveBurst((b % 2) == 0, ((b % 2) == 0) ? D_ADDR2 : I_ADDR2, 1'b0, 0, -1,
                 $sformatf("t3_b%0d", b));
    end
    applyStimulus(1'b0, I_ADDR2, 1'b0, 1'b0, D_ADDR2);

    // Stray beats in IDLE and ADDR are not forwarded and leave cnt at 0.
    mem_data_ok = 1'b1;
    #1;
    checkOutput("t4_idle_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    checkOutput("t4_idle_cnt", 32'(dut.beat_cnt), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, I_ADDR, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t4_grant_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, I_ADDR, 1'b0, 1'b0, 32'd0);
    #1;
    checkOutput("t4_addr_mem_req", 32'(mem_req), 32'd1);
    checkOutput("t4_addr_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    checkOutput("t4_addr_cnt", 32'(dut.beat_cnt), 32'd0);
    @(negedge clk);
    serveBurst(1'b0, I_ADDR, 1'b0, 0, -1, "t4");

    // dCache owner drops its request after beat 2; the burst still completes.
    applyStimulus(1'b0, I_ADDR, 1'b1, 1'b0, D_ADDR);
    @(negedge clk);
    serveBurst(1'b1, D_ADDR, 1'b0, 0, 2, "t5");
    @(negedge clk);
    #1;
    checkOutput("t5_no_regrant", 32'(busy), 32'd0);

    // Reset in DATA with cnt = 5, then a normal iCache burst.
    applyStimulus(1'b1, I_ADDR, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, I_ADDR, 1'b0, 1'b0, 32'd0);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_data_ok = 1'b1;
      @(negedge clk);
    end
    mem_data_ok = 1'b0;
    #1;
    checkOutput("t6_cnt_before", 32'(dut.beat_cnt), 32'd5);
    checkOutput("t6_busy_before", 32'(busy), 32'd1);
    reset       = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_busy",    32'(busy), 32'd0);
    checkOutput("t6_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t6_rst_cnt",     32'(dut.beat_cnt), 32'd0);
    checkOutput("t6_rst_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
    mem_data_ok = 1'b0;
    applyStimulus(1'b1, I_ADDR, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, I_ADDR, 1'b0, 1'b0, 32'd0);
    serveBurst(1'b0, I_ADDR, 1'b0, 0, -1, "t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
